// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: FSM encoding, parity modes and
// default oversampling constants (also consumed by the future uart_rx).
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam int OS_TICK_DEF = 16;
   localparam int SB_TICK_DEF = 16;

   // 2'b11 is reserved and behaves as no parity.
   function automatic logic par_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DBIT data bits LSB-first, optional
// even/odd parity and a stop period of SB_TICK baud ticks, paced by s_tick.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int OS_TICK = OS_TICK_DEF,
   parameter int SB_TICK = SB_TICK_DEF
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            tx_start,
   input  logic            s_tick,
   input  logic [DBIT-1:0] din,
   input  logic [1:0]      par_mode,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam int TMAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
   localparam int TW   = $clog2(TMAX);
   localparam int BW   = $clog2(DBIT);

   localparam logic [TW-1:0] OS_LAST  = TW'(OS_TICK - 1);
   localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

   state_t            state;
   logic [TW-1:0]     tick_cnt;
   logic [BW-1:0]     bit_cnt;
   logic [DBIT-1:0]   shreg;
   logic [1:0]        mode_reg;
   logic              par_bit;
   logic              tx_reg;

   // tx_reg is loaded with the level of the state being entered, so the line
   // is a pure flop output that always matches the current state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         mode_reg <= PAR_NONE;
         par_bit  <= 1'b0;
         tx_reg   <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               tx_reg <= 1'b1;
               if (tx_start) begin
                  shreg    <= din;
                  mode_reg <= par_mode;
                  par_bit  <= (par_mode == PAR_ODD) ? ~(^din) : (^din);
                  tick_cnt <= '0;
                  tx_reg   <= 1'b0;
                  state    <= ST_START;
               end
            end
            ST_START: begin
               if (s_tick) begin
                  if (tick_cnt == OS_LAST) begin
                     tick_cnt <= '0;
                     bit_cnt  <= '0;
                     tx_reg   <= shreg[0];
                     state    <= ST_DATA;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (s_tick) begin
                  if (tick_cnt == OS_LAST) begin
                     tick_cnt <= '0;
                     shreg    <= {1'b0, shreg[DBIT-1:1]};
                     if (bit_cnt == BIT_LAST) begin
                        if (par_enabled(mode_reg)) begin
                           tx_reg <= par_bit;
                           state  <= ST_PARITY;
                        end else begin
                           tx_reg <= 1'b1;
                           state  <= ST_STOP;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        tx_reg  <= shreg[1];
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (s_tick) begin
                  if (tick_cnt == OS_LAST) begin
                     tick_cnt <= '0;
                     tx_reg   <= 1'b1;
                     state    <= ST_STOP;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            ST_STOP: begin
               if (s_tick) begin
                  if (tick_cnt == SB_LAST) begin
                     tick_cnt <= '0;
                     state    <= ST_IDLE;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            default: begin
               tx_reg <= 1'b1;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx           = tx_reg;
   assign tx_busy      = (state != ST_IDLE);
   assign tx_done_tick = (state == ST_STOP) && s_tick && (tick_cnt == SB_LAST);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: frames are predicted from the line format
// rules and compared per baud tick by monitors triggered on tx_done_tick.
module tb_uart_tx_cfg;

   typedef struct {
      logic [8:0] data;
      logic [1:0] mode;
   } frame_t;
   typedef logic bitq_t [$];

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       s_tick = 1'b0;
   logic       start8 = 1'b0;
   logic       start7 = 1'b0;
   logic [7:0] din = '0;
   logic [1:0] par_mode = '0;
   logic       tx8, busy8, done8;
   logic       tx7, busy7, done7;

   int          n_checks = 0;
   int          n_fail = 0;
   frame_t      q8[$];
   frame_t      q7[$];
   frame_t      f8, f7;
   bitq_t       s8, s7;
   bit          post8 = 0;
   bit          post7 = 0;
   int unsigned tick_div = 4;
   bit          tick_hold = 0;

   always #5 clk = ~clk;

   uart_tx_cfg dut8 (
      .clk(clk), .reset_n(reset_n), .tx_start(start8), .s_tick(s_tick),
      .din(din), .par_mode(par_mode),
      .tx(tx8), .tx_busy(busy8), .tx_done_tick(done8)
   );

   uart_tx_cfg #(.DBIT(7), .OS_TICK(16), .SB_TICK(32)) dut7 (
      .clk(clk), .reset_n(reset_n), .tx_start(start7), .s_tick(s_tick),
      .din(din[6:0]), .par_mode(par_mode),
      .tx(tx7), .tx_busy(busy7), .tx_done_tick(done7)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected line level at baud tick k of a frame, straight from the frame format.
   function automatic logic model_bit(input int k, input int dbit, input int os, input frame_t f);
      int  b    = k / os;
      int  ones = $countones(f.data);
      bit  p    = (f.mode == 2'b01) || (f.mode == 2'b10);
      if (b == 0) return 1'b0;
      if (b <= dbit) return f.data[b-1];
      if (p && b == dbit + 1) begin
         if (f.mode == 2'b10) return (ones % 2 == 0) ? 1'b1 : 1'b0;
         return (ones % 2 == 1) ? 1'b1 : 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic check_frame(input string nm, input int dbit, input int os, input int sb,
                              input bitq_t smp, input frame_t f);
      int p   = ((f.mode == 2'b01) || (f.mode == 2'b10)) ? 1 : 0;
      int len = os * (1 + dbit + p) + sb;
      int bad = 0;
      check({nm, "_len"}, smp.size(), len);
      for (int k = 0; k < smp.size(); k++)
         if (smp[k] !== model_bit(k, dbit, os, f)) bad++;
      check({nm, "_bits"}, bad, 0);
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         s8.delete();
         post8 = 0;
      end else begin
         if (post8) begin
            check("done_width8", done8, 0);
            check("busy_drop8", busy8, 0);
            check("idle_gap8", tx8, 1);
            post8 = 0;
         end
         if (busy8 && s_tick) s8.push_back(tx8);
         if (done8) begin
            check("busy_at_done8", busy8, 1);
            if (q8.size() == 0) check("unexpected_frame8", 1, 0);
            else begin
               f8 = q8.pop_front();
               check_frame("frame8", 8, 16, 16, s8, f8);
            end
            s8.delete();
            post8 = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         s7.delete();
         post7 = 0;
      end else begin
         if (post7) begin
            check("done_width7", done7, 0);
            check("busy_drop7", busy7, 0);
            check("idle_gap7", tx7, 1);
            post7 = 0;
         end
         if (busy7 && s_tick) s7.push_back(tx7);
         if (done7) begin
            check("busy_at_done7", busy7, 1);
            if (q7.size() == 0) check("unexpected_frame7", 1, 0);
            else begin
               f7 = q7.pop_front();
               check_frame("frame7", 7, 16, 32, s7, f7);
            end
            s7.delete();
            post7 = 1;
         end
      end
   end

   initial begin
      int unsigned cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_hold) s_tick = 1'b1;
         else begin
            s_tick = (cnt == 0);
            cnt = (cnt + 1 >= tick_div) ? 0 : cnt + 1;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // All stimulus tasks start and end half a cycle before... at posedge+1.
   task automatic wait_idle(input int which);
      int n = 0;
      while (((which == 8) ? busy8 : busy7) && n < 5000) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 5000) check("timeout_idle", 0, 1);
   endtask

   task automatic wait_done(input int which);
      int n = 0;
      while ((which == 8 ? (q8.size() != 0 || busy8) : (q7.size() != 0 || busy7)) && n < 20000) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 20000) check("timeout_done", 0, 1);
   endtask

   task automatic wait_ticks(input int n);
      int seen = 0;
      int cyc = 0;
      while (seen < n && cyc < 20000) begin
         @(negedge clk); cyc++;
         if (s_tick) seen++;
      end
      if (seen < n) check("timeout_ticks", 0, 1);
   endtask

   task automatic send(input int which, input logic [7:0] d, input logic [1:0] m);
      frame_t f;
      wait_idle(which);
      din = d;
      par_mode = m;
      f.mode = m;
      if (which == 8) begin
         f.data = {1'b0, d};
         q8.push_back(f);
         start8 = 1'b1;
      end else begin
         f.data = {2'b00, d[6:0]};
         q7.push_back(f);
         start7 = 1'b1;
      end
      @(posedge clk); #1;
      start8 = 1'b0;
      start7 = 1'b0;
      if (which == 8) check("start_latency8", {tx8, busy8}, 2'b01);
      else            check("start_latency7", {tx7, busy7}, 2'b01);
   endtask

   task automatic pulse_start(input int which);
      @(posedge clk); #1;
      if (which == 8) start8 = 1'b1; else start7 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      start7 = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_tx8", tx8, 1);
      check("reset_busy8", busy8, 0);
      check("reset_done8", done8, 0);
      check("reset_tx7", tx7, 1);
      check("reset_busy7", busy7, 0);
      check("reset_done7", done7, 0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      send(8, 8'h55, 2'b00); wait_done(8);
      send(8, 8'h07, 2'b01); wait_done(8);
      send(8, 8'h07, 2'b10); wait_done(8);
      send(7, 8'h41, 2'b00); wait_done(7);

      // start request while busy must be dropped; next frame goes out back-to-back
      send(8, 8'h00, 2'b00);
      wait_ticks(40);
      din = 8'hFF;
      pulse_start(8);
      din = 8'h00;
      wait_done(8);
      send(8, 8'hC3, 2'b01);
      wait_done(8);

      // reset mid-frame while the line is low
      send(8, 8'h00, 2'b00);
      wait_ticks(70);
      #1 reset_n = 1'b0;
      #1;
      check("midreset_tx8", tx8, 1);
      check("midreset_busy8", busy8, 0);
      check("midreset_done8", done8, 0);
      q8.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      send(8, 8'hA5, 2'b00); wait_done(8);

      // continuous ticks while idle must not pre-load the tick counter
      tick_hold = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      send(8, 8'h3C, 2'b01);
      tick_hold = 1'b0;
      wait_done(8);

      for (int i = 0; i < 16; i++) begin
         int which;
         which = ($urandom_range(0, 3) == 0) ? 7 : 8;
         tick_div = $urandom_range(1, 6);
         send(which, 8'($urandom), 2'($urandom));
         wait_ticks($urandom_range(1, 100));
         din = 8'($urandom);
         par_mode = 2'($urandom);
         if ($urandom_range(0, 1) == 1) pulse_start(which);
         wait_done(which);
      end

      repeat (20) @(posedge clk);
      #1;
      check("end_q8_empty", q8.size(), 0);
      check("end_q7_empty", q7.size(), 0);
      check("end_busy8", busy8, 0);
      check("end_busy7", busy7, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised successor to the team's fixed 8N1 UART transmitter.
- Serialises a DBIT-wide word LSB-first: start bit, data bits, optional even/odd parity bit, then a configurable stop length.
- Bit timing is paced by an external baud-rate tick `s_tick` at OS_TICK ticks per bit.
- Sits between the TX FIFO/interface controller and the pad, and adds a busy flag for flow control.

Parameters:
- DBIT, 8, data bits per frame; legal 5..9.
- OS_TICK, 16, s_ticks per bit (start, data and parity bits); legal 8..32.
- SB_TICK, 16, s_ticks in the stop period; 16 = 1 stop, 24 = 1.5, 32 = 2 (at OS_TICK=16); legal 1..64.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tx_start  in  1  request to send; sampled only in IDLE.
- s_tick  in  1  one-cycle baud oversampling tick.
- din  in  DBIT  data word.
- par_mode  in  2  parity: 00 none, 01 even, 10 odd, 11 none (reserved).
- tx  out  1  serial line, registered, idle high.
- tx_busy  out  1  high whenever state != IDLE.
- tx_done_tick  out  1  one-cycle pulse at end of stop period.

Behaviour:
- Reset (reset_n=0, immediate, asynchronous): state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, all counters/buffers 0.
- States: IDLE, START, DATA, PARITY, STOP. Encoding comes from the package.
- IDLE:
  - tx=1; s_tick is ignored.
  - When tx_start=1 in cycle N: latch din into the shift buffer and par_mode into a mode register. Compute the parity bit from din: even → XOR of din; odd → inverted XOR.
  - Clear the tick counter; go to START.
  - tx=0 and tx_busy=1 from cycle N+1.
- START: tx=0. Count s_ticks. On the OS_TICK-th tick, clear the tick counter and bit counter, then go to DATA.
- DATA:
  - tx = buffer[0].
  - On the OS_TICK-th tick, shift the buffer right and clear the tick counter.
  - If the bit counter = DBIT-1: go to PARITY if the latched mode is 01/10, otherwise go to STOP. Else increment the bit counter.
- PARITY: tx = latched parity bit. On the OS_TICK-th tick, clear the tick counter and go to STOP.
- STOP:
  - tx=1.
  - On the SB_TICK-th tick: tx_done_tick=1 for that single cycle (combinational with that s_tick), then go to IDLE. tx_busy drops the following cycle.
- tx_start while busy: ignored; no queueing, no corruption.
- tx_start in the first IDLE cycle after done: accepted (back-to-back frames, 1-cycle idle-high gap).
- din/par_mode changes mid-frame: no effect; both are latched at start.
- Tick counter width: $clog2 of max(OS_TICK, SB_TICK). Bit counter width: $clog2(DBIT). Counters never wrap within a bit.
- Frame length in ticks: OS_TICK*(1+DBIT+P) + SB_TICK, where P = 1 with parity, 0 without.
- Reset mid-frame: tx returns to 1 immediately. No done pulse. The next tx_start after release is a clean frame.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings (ST_IDLE..ST_STOP, 3 bits)
  - parity-mode constants PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10
  - default OS_TICK/SB_TICK constants, shared with the future configurable uart_rx.
- No sub-module; a single FSMD with registered outputs, about 150-200 lines.

Test Plan:
- DBIT=8, par_mode=00, din=0x55, s_tick every 4 clk → tx = 0,1,0,1,0,1,0,1,0 then stop 1. Each bit lasts 16 ticks; done pulse after 160 ticks; tx_busy high throughout.
- par_mode=01, din=0x07 → parity bit 1. par_mode=10, din=0x07 → parity bit 0. Frame = 176 ticks.
- Instance DBIT=7, SB_TICK=32, din=0x41, par_mode=00 → 7 data bits 1,0,0,0,0,0,1, stop held high for 32 ticks, done after 160 ticks.
- tx_start pulsed with din=0xFF at tick 40 of a 0x00 frame → transmitted bits stay all 0, with no second frame. tx_start in the cycle after done → next frame's start bit appears on the following cycle.
- reset_n low at tick 70 of a frame → tx=1 and tx_busy=0 in the same cycle with no done pulse. After release, tx_start with din=0xA5 → correct full frame.
- s_tick held high for 50 cycles while idle, then tx_start → frame timing still starts from a zeroed counter (exactly OS_TICK ticks of start bit).
